// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the button-driven ALU front end: opcode constants
// (6-bit function codes) and the operand-loading FSM state type.
// No ports; imported by alu_input_ctrl.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

  // Encodings are driven straight onto LEDs, so they are fixed explicitly.
  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OP  = 2'd2,
    S_RES = 2'd3
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Turns one raw, asynchronous, possibly bouncing push-button into a single
// one-clock pulse per press.
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   btn    : raw button level
//   pulse  : one-clock press pulse
// Build option ALU_DEBOUNCE_EN: when defined, the press must be stable high
// for DEB_CYCLES clocks before the pulse, and stable low for DEB_CYCLES
// clocks before the next press is accepted. When undefined, the pulse fires
// on the synchronized rising edge and no counter exists.
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  if (DEB_CYCLES < 2) begin : g_deb_check
    $error("btn_debounce: DEB_CYCLES must be at least 2");
  end

  logic       sync1;
  logic       sync2;
  logic [1:0] fill;
  logic       live;
  logic       armed;

  // fill marks when sync2 holds a sample taken after reset, so the cleared
  // synchronizer is never mistaken for a released button. armed is only set
  // by a genuine low, which keeps a button held through reset from firing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      fill  <= 2'b00;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
    end
  end

  assign live = fill[1];

`ifdef ALU_DEBOUNCE_EN
  localparam int unsigned            CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             want;
  logic             done;

  // want: the synchronized level is the one that would change armed.
  assign want  = armed ? sync2 : (live & ~sync2);
  assign done  = want && (cnt == CNT_LAST);
  assign pulse = armed & done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (!want) begin
      cnt   <= '0;
    end else if (done) begin
      cnt   <= '0;
      armed <= ~armed;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end
`else
  assign pulse = armed & sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed <= 1'b0;
    end else if (pulse) begin
      armed <= 1'b0;
    end else if (live & ~sync2) begin
      armed <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/alu_input_ctrl.sv
// -----------------------------------------------------------------------------
// alu_input_ctrl
// Three push-buttons sequence operand A, operand B and an opcode from a
// switch bus into registers; a registered ALU result and flags follow.
//   clk       : system clock
//   reset     : asynchronous active-high reset
//   pulsador  : raw buttons [0]=load A, [1]=load B, [2]=load opcode
//   entrada   : switch bus (operand, or opcode in [COD_OP-1:0])
//   ALU_Out   : registered result
//   o_zero, o_carry, o_ovf : registered flags aligned with ALU_Out
//   o_valid   : ALU_Out reflects the loaded A, B and opcode (in S_RES)
//   o_state   : FSM state encoding for LEDs
// Build option ALU_DEBOUNCE_EN selects debounced press detection in
// btn_debounce (DEB_CYCLES stability window).
// -----------------------------------------------------------------------------
module alu_input_ctrl
  import alu_pkg::*;
#(
  parameter int          NBITS      = 8,
  parameter int          COD_OP     = 6,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        pulsador,
  input  logic [NBITS-1:0]  entrada,
  output logic [NBITS-1:0]  ALU_Out,
  output logic              o_zero,
  output logic              o_carry,
  output logic              o_ovf,
  output logic              o_valid,
  output logic [1:0]        o_state
);

  if (NBITS < 4 || NBITS > 32) begin : g_nbits_check
    $error("alu_input_ctrl: NBITS must be within 4..32");
  end

  localparam int MSB  = NBITS - 1;
  localparam int SH_W = $clog2(NBITS);

  logic [2:0]        pulse;
  state_t            state;
  state_t            next_state;
  logic              ld_a;
  logic              ld_b;
  logic              ld_op;
  logic [NBITS-1:0]  a_reg;
  logic [NBITS-1:0]  b_reg;
  logic [COD_OP-1:0] op_reg;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
      .clk   (clk),
      .reset (reset),
      .btn   (pulsador[i]),
      .pulse (pulse[i])
    );
  end

  // Only the button the current state waits for can act; others are ignored.
  always_comb begin
    next_state = state;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    ld_op      = 1'b0;
    case (state)
      S_A:   if (pulse[0]) begin ld_a  = 1'b1; next_state = S_B;   end
      S_B:   if (pulse[1]) begin ld_b  = 1'b1; next_state = S_OP;  end
      S_OP:  if (pulse[2]) begin ld_op = 1'b1; next_state = S_RES; end
      S_RES: if (pulse[0]) begin ld_a  = 1'b1; next_state = S_B;   end
      default: next_state = S_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_A;
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= '0;
    end else begin
      state <= next_state;
      if (ld_a)  a_reg  <= entrada;
      if (ld_b)  b_reg  <= entrada;
      if (ld_op) op_reg <= entrada[COD_OP-1:0];
    end
  end

  assign o_state = state;

  // ---- stage p0: combinational ALU on the operand/opcode registers ----
  logic                    [NBITS-1:0] res_p0;
  logic                    [NBITS:0]   sum_p0;
  logic                                carry_p0;
  logic                                ovf_p0;
  logic                                zero_p0;
  logic signed             [NBITS-1:0] a_s;
  logic                    [SH_W-1:0]  shamt;

  assign a_s   = $signed(a_reg);
  assign shamt = b_reg[SH_W-1:0];

  always_comb begin
    res_p0   = '0;
    sum_p0   = '0;
    carry_p0 = 1'b0;
    ovf_p0   = 1'b0;
    case (op_reg)
      COD_OP'(OP_ADD): begin
        sum_p0   = {1'b0, a_reg} + {1'b0, b_reg};
        res_p0   = sum_p0[NBITS-1:0];
        carry_p0 = sum_p0[NBITS];
        ovf_p0   = (a_reg[MSB] == b_reg[MSB]) && (res_p0[MSB] != a_reg[MSB]);
      end
      COD_OP'(OP_SUB): begin
        sum_p0   = {1'b0, a_reg} + {1'b0, ~b_reg} + 1'b1;
        res_p0   = sum_p0[NBITS-1:0];
        carry_p0 = sum_p0[NBITS];
        ovf_p0   = (a_reg[MSB] != b_reg[MSB]) && (res_p0[MSB] != a_reg[MSB]);
      end
      COD_OP'(OP_AND): res_p0 = a_reg & b_reg;
      COD_OP'(OP_OR):  res_p0 = a_reg | b_reg;
      COD_OP'(OP_XOR): res_p0 = a_reg ^ b_reg;
      COD_OP'(OP_NOR): res_p0 = ~(a_reg | b_reg);
      COD_OP'(OP_SRA): res_p0 = a_s >>> shamt;
      COD_OP'(OP_SRL): res_p0 = a_reg >> shamt;
      default:         res_p0 = '0;
    endcase
  end

  assign zero_p0 = (res_p0 == '0);

  // ---- stage p1: registered result, flags and valid ----
  // Valid needs a full clock in S_RES so the result register has caught up
  // with the opcode load, and drops on the same edge that leaves S_RES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALU_Out <= '0;
      o_zero  <= 1'b0;
      o_carry <= 1'b0;
      o_ovf   <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      ALU_Out <= res_p0;
      o_zero  <= zero_p0;
      o_carry <= carry_p0;
      o_ovf   <= ovf_p0;
      o_valid <= (state == S_RES) && (next_state == S_RES);
    end
  end

endmodule

// File: tb/tb_alu_input_ctrl.sv
module tb_alu_input_ctrl;

  localparam int HOLD = 10;
  localparam int REL  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] pulsador = 3'b000;
  logic [7:0] entrada = 8'h00;
  logic [7:0] ALU_Out;
  logic       o_zero, o_carry, o_ovf, o_valid;
  logic [1:0] o_state;

  int checks = 0;
  int errors = 0;

  // reference model of the loaded registers and sequencing
  int m_st = 0;
  int m_a  = 0;
  int m_b  = 0;
  int m_op = 0;

  always #5 clk = ~clk;

  alu_input_ctrl #(.NBITS(8), .COD_OP(6), .DEB_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .pulsador (pulsador),
    .entrada  (entrada),
    .ALU_Out  (ALU_Out),
    .o_zero   (o_zero),
    .o_carry  (o_carry),
    .o_ovf    (o_ovf),
    .o_valid  (o_valid),
    .o_state  (o_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // returns {zero, carry, ovf, result[7:0]}
  function automatic logic [10:0] ref_alu(input int a, input int b, input int op);
    int r, sa, sb, s, sh;
    logic c, v;
    r = 0; c = 1'b0; v = 1'b0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    sh = b % 8;
    case (op)
      32: begin r = a + b;             c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      34: begin r = a + (255 - b) + 1; c = (r > 255); s = sa - sb; v = (s > 127) || (s < -128); end
      36: r = a & b;
      37: r = a | b;
      38: r = a ^ b;
      39: r = 255 - (a | b);
      3:  r = sa >>> sh;
      2:  r = a >> sh;
      default: r = 0;
    endcase
    r = r & 255;
    return {(r == 0), c, v, r[7:0]};
  endfunction

  task automatic model_press(input logic [2:0] m, input logic [7:0] val);
    case (m_st)
      0: if (m[0]) begin m_a = int'(val); m_st = 1; end
      1: if (m[1]) begin m_b = int'(val); m_st = 2; end
      2: if (m[2]) begin m_op = int'(val) & 63; m_st = 3; end
      default: if (m[0]) begin m_a = int'(val); m_st = 1; end
    endcase
  endtask

  task automatic do_press(input logic [2:0] m, input logic [7:0] val);
    @(posedge clk); #1;
    entrada  = val;
    pulsador = m;
    repeat (HOLD) @(posedge clk);
    #1 pulsador = 3'b000;
    repeat (REL) @(posedge clk);
    @(negedge clk);
    model_press(m, val);
  endtask

  task automatic check_all(input string tag);
    logic [10:0] e;
    e = ref_alu(m_a, m_b, m_op);
    chk({tag, "_out"},   {24'd0, ALU_Out},     {24'd0, e[7:0]});
    chk({tag, "_zero"},  {31'd0, o_zero},      {31'd0, e[10]});
    chk({tag, "_carry"}, {31'd0, o_carry},     {31'd0, e[9]});
    chk({tag, "_ovf"},   {31'd0, o_ovf},       {31'd0, e[8]});
    chk({tag, "_state"}, {30'd0, o_state},     32'(m_st));
    chk({tag, "_valid"}, {31'd0, o_valid},     {31'd0, (m_st == 3)});
  endtask

  task automatic check_zeroed(input string tag);
    chk({tag, "_out"},   {24'd0, ALU_Out}, 32'd0);
    chk({tag, "_zero"},  {31'd0, o_zero},  32'd0);
    chk({tag, "_carry"}, {31'd0, o_carry}, 32'd0);
    chk({tag, "_ovf"},   {31'd0, o_ovf},   32'd0);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
    chk({tag, "_state"}, {30'd0, o_state}, 32'd0);
  endtask

  initial begin
    logic [7:0] v1, v2, val;
    logic [2:0] m;
    int         opsel;
    int         ops[8] = '{32, 34, 36, 37, 38, 39, 3, 2};

    // reset state
    repeat (3) @(negedge clk);
    check_zeroed("reset");
    reset = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_all("idle");

    // B button in S_A is ignored
    do_press(3'b010, 8'h55);
    check_all("b_in_sa");

    // ADD with signed overflow
    do_press(3'b001, 8'h7F);
    do_press(3'b010, 8'h01);
    do_press(3'b100, 8'h20);
    chk("add_out_const", {24'd0, ALU_Out}, 32'h80);
    chk("add_ovf_const", {31'd0, o_ovf}, 32'd1);
    check_all("add");

    // SUB to zero with carry
    do_press(3'b001, 8'h05);
    check_all("leave_res");
    do_press(3'b010, 8'h05);
    do_press(3'b100, 8'h22);
    chk("sub_carry_const", {31'd0, o_carry}, 32'd1);
    check_all("sub");

    // SRA, then opcode button in S_RES ignored
    do_press(3'b001, 8'h80);
    do_press(3'b010, 8'h01);
    do_press(3'b100, 8'h03);
    chk("sra_out_const", {24'd0, ALU_Out}, 32'hC0);
    check_all("sra");
    do_press(3'b100, 8'h02);
    chk("op_in_res_const", {24'd0, ALU_Out}, 32'hC0);
    check_all("op_in_res");
    do_press(3'b010, 8'h07);
    check_all("b_in_res");

    // bouncing A button from S_RES
    v1 = 8'h3C;
    v2 = 8'hA5;
    @(posedge clk); #1;
    entrada = v1;
    for (int i = 0; i < 10; i++) begin
      pulsador = (i % 2 == 0) ? 3'b001 : 3'b000;
      repeat (2) @(posedge clk);
      #1;
    end
    entrada  = v2;
    pulsador = 3'b001;
    repeat (HOLD) @(posedge clk);
    #1 pulsador = 3'b000;
    repeat (REL) @(posedge clk);
    @(negedge clk);
`ifdef ALU_DEBOUNCE_EN
    m_a = int'(v2);
`else
    m_a = int'(v1);
`endif
    m_st = 1;
    check_all("bounce");
    do_press(3'b010, 8'h00);
    do_press(3'b100, 8'h25);
    check_all("bounce_or");

    // randomized press sequences, including simultaneous buttons
    for (int n = 0; n < 40; n++) begin
      m = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 3) != 0) begin
        m = (m_st == 1) ? 3'b010 : (m_st == 2) ? 3'b100 : 3'b001;
        if ($urandom_range(0, 3) == 0) m = m | 3'($urandom_range(0, 7));
      end
      val = 8'($urandom);
      if (m_st == 2 && m[2]) begin
        opsel = $urandom_range(0, 8);
        if (opsel < 8) val = {val[7:6], 6'(ops[opsel])};
      end
      do_press(m, val);
      check_all("rand");
    end

    // reset in S_OP with buttons held
    if (m_st == 2) do_press(3'b100, 8'h20);
    if (m_st == 1) begin do_press(3'b010, 8'h00); do_press(3'b100, 8'h03); end
    do_press(3'b001, 8'h40);
    do_press(3'b010, 8'h00);
    check_all("pre_reset");
    @(posedge clk); #1;
    pulsador = 3'b100;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_zeroed("async_reset");
    pulsador = 3'b101;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    m_st = 0; m_a = 0; m_b = 0; m_op = 0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check_all("held_through_reset");
    #1 pulsador = 3'b000;
    repeat (REL) @(posedge clk);
    @(negedge clk);
    check_all("released");
    do_press(3'b001, 8'h0F);
    check_all("repress");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_input_ctrl.md
ALU_INPUT_CTRL -- requirements
Module: alu_input_ctrl

Interface
REQ-001 Parameter NBITS, default 8: operand and result width; legal values 4..32.
REQ-002 Parameter COD_OP, default 6: opcode width.
REQ-003 Parameter DEB_CYCLES, default 1_000_000: debounce stability window in clk cycles; legal values >= 2.
REQ-004 clk  input  1  single system clock; all state rising-edge triggered.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pulsador  input  3  raw push-buttons: [0]=load A, [1]=load B, [2]=load opcode; asynchronous, may bounce.
REQ-007 entrada  input  NBITS  switch bus; operand, or opcode in bits [COD_OP-1:0].
REQ-008 ALU_Out  output  NBITS  registered result.
REQ-009 o_zero / o_carry / o_ovf  output  1 each  registered flags aligned with ALU_Out.
REQ-010 o_valid  output  1  high while ALU_Out matches the currently loaded A, B and opcode.
REQ-011 o_state  output  2  current FSM state encoding, for LEDs.

Function
REQ-012 Each pulsador bit SHALL pass through a 2-FF synchronizer, then press detection, producing a one-clk pulse per press.
REQ-013 FSM states: S_A=0, S_B=1, S_OP=2, S_RES=3; o_state SHALL equal the encoding.
REQ-014 S_A: pulse[0] loads entrada into A, goes to S_B; S_B: pulse[1] loads B, goes to S_OP; S_OP: pulse[2] loads entrada[COD_OP-1:0] into opcode, goes to S_RES.
REQ-015 S_RES: pulse[0] loads A and goes to S_B (new operation); pulse[1]/pulse[2] ignored.
REQ-016 In any state, pulses of non-expected buttons SHALL be ignored; simultaneous pulses: only the expected one acts.
REQ-017 Opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010.
REQ-018 Shift amount SHALL be B[$clog2(NBITS)-1:0]; SRA sign-fills, SRL zero-fills.
REQ-019 ADD/SUB computed at NBITS+1 width: o_carry = carry-out of A+B (ADD) or A+~B+1 (SUB); o_ovf = two's-complement signed overflow; carry/ovf SHALL be 0 for all other ops.
REQ-020 o_zero SHALL be 1 when result == 0, for every op.
REQ-021 Undefined opcode: result 0, o_zero=1, o_carry=0, o_ovf=0.
REQ-022 ALU_Out and flags SHALL register the combinational result every clk; latency = 1 clk from operand/opcode register update.
REQ-023 o_valid SHALL rise 1 clk after entering S_RES and fall on the clk edge that leaves S_RES.
REQ-024 A, B, opcode registers SHALL hold value across all states until explicitly reloaded.

Reset
REQ-025 Asserting reset SHALL at once force state S_A, A=B=0, opcode=0, ALU_Out=0, o_zero=0, o_carry=0, o_ovf=0, o_valid=0, synchronizers and debounce counters cleared.
REQ-026 Reset mid-operation (any state, button held) SHALL discard partial loads; a button held through reset release SHALL NOT produce a pulse until released and pressed again.

Configuration
REQ-027 Macro ALU_DEBOUNCE_EN defined: press pulse SHALL fire only after the synchronized input is stable high DEB_CYCLES consecutive clks; re-arming requires stable low DEB_CYCLES clks.
REQ-028 ALU_DEBOUNCE_EN undefined: pulse SHALL fire on the synchronized rising edge (3 clks after input rise); DEB_CYCLES unused; no counters synthesized.

Structure
REQ-029 Package alu_pkg SHALL hold the opcode constants, FSM state typedef and state encodings.
REQ-030 One sub-module, btn_debounce (sync + debounce/edge, one pulse output), SHALL be instantiated three times.

Verification (DEB_CYCLES=4 with macro, plus one run without)
REQ-031 Load A=8'h7F, B=8'h01, op=100000 -> ALU_Out=8'h80, o_ovf=1, o_carry=0, o_zero=0, o_valid=1.
REQ-032 A=8'h05, B=8'h05, op=100010 -> ALU_Out=8'h00, o_zero=1, o_carry=1, o_ovf=0.
REQ-033 A=8'h80, B=8'h01, op=000011 -> 8'hC0; then reload op=000010 requires new A first (press[2] in S_RES ignored, ALU_Out stays 8'hC0).
REQ-034 Bounce on pulsador[0] (toggles every 2 clks for 20 clks, then stable high 4 clks) -> exactly one A load; without macro, first edge loads A.
REQ-035 Reset asserted in S_OP with pulsador[2] held -> state S_A, all outputs 0; no load until release and re-press.
REQ-036 Press pulsador[1] in S_A -> state stays S_A, B unchanged.
